// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: bundles the fetch, loader and program-memory signals of
// the instruction-memory arbiter. The arbiter uses the slave modport; the
// requesters and the memory use the master modport.
interface imem_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    // fetch stage (read requester)
    logic                  fetch_req;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_gnt;
    logic                  fetch_rvalid;
    logic [DATA_WIDTH-1:0] fetch_rdata;
    // program loader (write requester)
    logic                  load_req;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic [DATA_WIDTH-1:0] load_wdata;
    logic                  load_last;
    logic                  load_gnt;
    // pipeline freeze
    logic                  pipe_stall;
    // single-port program memory
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  fetch_req, fetch_addr, load_req, load_addr, load_wdata, load_last, mem_rdata,
        output fetch_gnt, fetch_rvalid, fetch_rdata, load_gnt, pipe_stall,
               mem_addr, mem_we, mem_wdata
    );

    modport master (
        output fetch_req, fetch_addr, load_req, load_addr, load_wdata, load_last, mem_rdata,
        input  fetch_gnt, fetch_rvalid, fetch_rdata, load_gnt, pipe_stall,
               mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-port program memory between the fetch
// stage (reads) and the program loader (writes). The loader has priority;
// a non-final burst is locked, with one forced fetch slot after every
// MAX_BURST consecutive writes. pipe_stall freezes the pipeline whenever
// fetch is requesting but not granted.
// Optional build macro IMEM_ARB_STATS_EN adds a saturating 16-bit count of
// stalled cycles on output stall_cycles.
module imem_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8
) (
    input  logic          clk,
    input  logic          reset,
    imem_arbiter_if.slave bus
`ifdef IMEM_ARB_STATS_EN
    ,
    output logic [15:0]   stall_cycles
`endif
);

    localparam int BCNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_YIELD = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
    logic [BCNT_W-1:0]     bcnt_inc_s;
    logic                  fetch_rvalid_q;
    logic                  load_gnt_raw_s;
    logic                  fetch_gnt_raw_s;
    logic                  load_gnt_s;
    logic                  fetch_gnt_s;
    logic                  pipe_stall_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic [DATA_WIDTH-1:0] mem_wdata_s;

    assign bcnt_inc_s = bcnt_q + BCNT_W'(1);

    // Next-state, burst counter and raw grant decode
    always_comb begin
        state_d         = state_q;
        bcnt_d          = bcnt_q;
        load_gnt_raw_s  = 1'b0;
        fetch_gnt_raw_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.load_req) begin
                    load_gnt_raw_s = 1'b1;
                    if (bus.load_last) begin
                        state_d = ST_IDLE;
                        bcnt_d  = BCNT_W'(0);
                    end else if (BCNT_W'(1) == BCNT_W'(MAX_BURST)) begin
                        // a one-write limit is already reached by this first write
                        state_d = ST_YIELD;
                        bcnt_d  = BCNT_W'(1);
                    end else begin
                        state_d = ST_LOAD;
                        bcnt_d  = BCNT_W'(1);
                    end
                end else begin
                    fetch_gnt_raw_s = bus.fetch_req;
                end
            end
            ST_LOAD: begin
                if (bus.load_req) begin
                    load_gnt_raw_s = 1'b1;
                    if (bus.load_last) begin
                        // end of burst takes precedence over the burst limit
                        state_d = ST_IDLE;
                        bcnt_d  = BCNT_W'(0);
                    end else if (bcnt_inc_s == BCNT_W'(MAX_BURST)) begin
                        state_d = ST_YIELD;
                        bcnt_d  = bcnt_inc_s;
                    end else begin
                        state_d = ST_LOAD;
                        bcnt_d  = bcnt_inc_s;
                    end
                end else begin
                    // loader paused inside a burst: fetch may use the gap, count holds
                    fetch_gnt_raw_s = bus.fetch_req;
                end
            end
            ST_YIELD: begin
                fetch_gnt_raw_s = bus.fetch_req;
                state_d         = ST_LOAD;
                bcnt_d          = BCNT_W'(0);
            end
            default: begin
                state_d = ST_IDLE;
                bcnt_d  = BCNT_W'(0);
            end
        endcase
    end

    // Reset gating of grants and memory-side muxing
    always_comb begin
        load_gnt_s   = load_gnt_raw_s & ~reset;
        fetch_gnt_s  = fetch_gnt_raw_s & ~reset;
        pipe_stall_s = bus.fetch_req & ~fetch_gnt_s & ~reset;
        mem_wdata_s  = bus.load_wdata;
        if (load_gnt_s) begin
            mem_addr_s = bus.load_addr;
        end else begin
            mem_addr_s = bus.fetch_addr;
        end
    end

    // State, burst counter and read-valid registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            bcnt_q         <= BCNT_W'(0);
            fetch_rvalid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            bcnt_q         <= bcnt_d;
            fetch_rvalid_q <= fetch_gnt_s;
        end
    end

    assign bus.load_gnt     = load_gnt_s;
    assign bus.fetch_gnt    = fetch_gnt_s;
    assign bus.pipe_stall   = pipe_stall_s;
    assign bus.mem_we       = load_gnt_s;
    assign bus.mem_addr     = mem_addr_s;
    assign bus.mem_wdata    = mem_wdata_s;
    assign bus.fetch_rvalid = fetch_rvalid_q;
    assign bus.fetch_rdata  = bus.mem_rdata;

`ifdef IMEM_ARB_STATS_EN
    logic [15:0] stall_cycles_q;

    // Saturating count of cycles in which the pipeline was stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= 16'h0000;
        end else if (pipe_stall_s && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_q <= stall_cycles_q + 16'h0001;
        end else begin
            stall_cycles_q <= stall_cycles_q;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule
